// File: rtl/seq_compare_if.sv
// Request/response bundle for the multi-cycle magnitude comparator.
// The master side issues operands and consumes the result; the slave side is the comparator.
interface seq_compare_if #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
);
    localparam int N  = WIDTH / CHUNK;
    localparam int CW = $clog2(N) + 1;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic [2:0]       comp;
    logic             is_signed;
    logic             out_valid;
    logic             out_ready;
    logic             cmp_result;
    logic             less;
    logic             equal;
    logic [CW-1:0]    slices_used;

    modport master (
        output in_valid, src_a, src_b, comp, is_signed, out_ready,
        input  in_ready, out_valid, cmp_result, less, equal, slices_used
    );

    modport slave (
        input  in_valid, src_a, src_b, comp, is_signed, out_ready,
        output in_ready, out_valid, cmp_result, less, equal, slices_used
    );
endinterface

// File: rtl/seq_compare.sv
// Slice-serial magnitude comparator: scans operands MSB-slice first and stops at the
// first differing slice, then holds the decoded result until the consumer accepts it.
module seq_compare #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic       clk,
    input  logic       rst,
    seq_compare_if.slave bus
);
    localparam int N  = WIDTH / CHUNK;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(N) + 1;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_SCAN = 2'b01;
    localparam logic [1:0] S_DONE = 2'b10;

    logic [1:0]       state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [2:0]       comp_q, comp_d;
    logic             sgn_q, sgn_d;
    logic             less_q, less_d;
    logic             equal_q, equal_d;
    logic             cmp_result_q, cmp_result_d;
    logic [CW-1:0]    slices_used_q, slices_used_d;
    logic [CHUNK-1:0] slice_a, slice_b;
    logic             slice_lt;

    function automatic logic eval_code(input logic [2:0] code, input logic lt, input logic eq);
        case (code)
            3'b000:  eval_code = lt;
            3'b001:  eval_code = ~(lt | eq);
            3'b010:  eval_code = lt | eq;
            3'b011:  eval_code = ~lt;
            3'b110:  eval_code = eq;
            3'b100:  eval_code = ~eq;
            default: eval_code = lt;
        endcase
    endfunction

    always_comb begin
        slice_a = a_q[int'(idx_q)*CHUNK +: CHUNK];
        slice_b = b_q[int'(idx_q)*CHUNK +: CHUNK];
        // Flipping the sign bit of the top slice turns a two's-complement order into an unsigned one.
        if (sgn_q && (idx_q == IW'(N - 1))) begin
            slice_a[CHUNK-1] = ~slice_a[CHUNK-1];
            slice_b[CHUNK-1] = ~slice_b[CHUNK-1];
        end
        slice_lt = slice_a < slice_b;

        state_d       = state_q;
        idx_d         = idx_q;
        cnt_d         = cnt_q;
        a_d           = a_q;
        b_d           = b_q;
        comp_d        = comp_q;
        sgn_d         = sgn_q;
        less_d        = less_q;
        equal_d       = equal_q;
        cmp_result_d  = cmp_result_q;
        slices_used_d = slices_used_q;

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.src_a;
                    b_d     = bus.src_b;
                    comp_d  = bus.comp;
                    sgn_d   = bus.is_signed;
                    idx_d   = IW'(N - 1);
                    cnt_d   = '0;
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                cnt_d = cnt_q + CW'(1);
                if (slice_a != slice_b) begin
                    less_d        = slice_lt;
                    equal_d       = 1'b0;
                    cmp_result_d  = eval_code(comp_q, slice_lt, 1'b0);
                    slices_used_d = cnt_q + CW'(1);
                    state_d       = S_DONE;
                end else if (idx_q == '0) begin
                    less_d        = 1'b0;
                    equal_d       = 1'b1;
                    cmp_result_d  = eval_code(comp_q, 1'b0, 1'b1);
                    slices_used_d = cnt_q + CW'(1);
                    state_d       = S_DONE;
                end else begin
                    idx_d = idx_q - IW'(1);
                end
            end
            S_DONE: begin
                if (bus.out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            idx_q         <= '0;
            cnt_q         <= '0;
            comp_q        <= '0;
            sgn_q         <= 1'b0;
            less_q        <= 1'b0;
            equal_q       <= 1'b0;
            cmp_result_q  <= 1'b0;
            slices_used_q <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            cnt_q         <= cnt_d;
            comp_q        <= comp_d;
            sgn_q         <= sgn_d;
            less_q        <= less_d;
            equal_q       <= equal_d;
            cmp_result_q  <= cmp_result_d;
            slices_used_q <= slices_used_d;
        end
    end

    // Operands are pure data: loaded only on accept, never cleared.
    always_ff @(posedge clk) begin
        a_q <= a_d;
        b_q <= b_d;
    end

    assign bus.in_ready    = (state_q == S_IDLE);
    assign bus.out_valid   = (state_q == S_DONE);
    assign bus.cmp_result  = cmp_result_q;
    assign bus.less        = less_q;
    assign bus.equal       = equal_q;
    assign bus.slices_used = slices_used_q;
endmodule

// File: tb/tb_seq_compare.sv
// Directed bench for seq_compare: the driver queues hand-computed expectations,
// an independent monitor pops them whenever a result is handed off.
module tb_seq_compare;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seq_compare_if #(.WIDTH(32), .CHUNK(8)) bus ();
    seq_compare #(.WIDTH(32), .CHUNK(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic less;
        logic equal;
        logic cmp;
        int   used;
        int   acc;
    } exp_t;

    exp_t q[$];
    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;
    int fv     = 0;
    logic prev_v = 1'b0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec = n_vec + 1;
        if (act != exp) begin
            n_miss = n_miss + 1;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: samples on the falling edge, a handoff happens on the next rising edge.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_v = 1'b0;
        end else begin
            if (bus.out_valid && !prev_v) fv = cyc;
            prev_v = bus.out_valid;
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("less", int'(bus.less), int'(e.less));
                    chk("equal", int'(bus.equal), int'(e.equal));
                    chk("cmp_result", int'(bus.cmp_result), int'(e.cmp));
                    chk("slices_used", int'(bus.slices_used), e.used);
                    chk("latency", fv - e.acc + 1, e.used + 1);
                end
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [2:0] c,
                         input logic s, input logic el, input logic ee, input logic ec,
                         input int eu, input bit push);
        exp_t e;
        int guard = 0;
        while (!bus.in_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 100) chk("in_ready_timeout", 0, 1);
        bus.src_a = a;
        bus.src_b = b;
        bus.comp = c;
        bus.is_signed = s;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        if (push) begin
            e.less = el; e.equal = ee; e.cmp = ec; e.used = eu; e.acc = cyc;
            q.push_back(e);
        end
    endtask

    task automatic drain();
        int guard = 0;
        while ((q.size() != 0 || bus.out_valid) && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 50) chk("drain_timeout", 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        int seen;
        bus.in_valid = 1'b0;
        bus.src_a = '0;
        bus.src_b = '0;
        bus.comp = '0;
        bus.is_signed = 1'b0;
        bus.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_in_ready", int'(bus.in_ready), 1);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_less", int'(bus.less), 0);
        chk("rst_equal", int'(bus.equal), 0);
        chk("rst_cmp", int'(bus.cmp_result), 0);
        chk("rst_used", int'(bus.slices_used), 0);

        issue(32'h12345678, 32'h12345678, 3'b110, 1'b0, 1'b0, 1'b1, 1'b1, 4, 1'b1); drain();
        issue(32'h80000000, 32'h00000001, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b1); drain();
        issue(32'h80000000, 32'h00000001, 3'b000, 1'b1, 1'b1, 1'b0, 1'b1, 1, 1'b1); drain();
        issue(32'h000000FF, 32'h00000100, 3'b001, 1'b0, 1'b1, 1'b0, 1'b0, 3, 1'b1); drain();
        issue(32'h000000FF, 32'h00000100, 3'b011, 1'b0, 1'b1, 1'b0, 1'b0, 3, 1'b1); drain();

        // Reset during the second scan cycle of an equal-operand request.
        issue(32'h12345678, 32'h12345678, 3'b110, 1'b0, 1'b0, 1'b1, 1'b1, 4, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_out_valid", int'(bus.out_valid), 0);
        chk("rst_mid_outputs", int'({bus.less, bus.equal, bus.cmp_result, bus.slices_used}), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_mid_in_ready", int'(bus.in_ready), 1);
        seen = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen++;
        end
        chk("rst_mid_no_result", seen, 0);

        issue(32'd5, 32'd9, 3'b101, 1'b0, 1'b1, 1'b0, 1'b1, 4, 1'b1); drain();
        issue(32'd5, 32'd9, 3'b111, 1'b0, 1'b1, 1'b0, 1'b1, 4, 1'b1); drain();
        issue(32'd9, 32'd5, 3'b101, 1'b0, 1'b0, 1'b0, 1'b0, 4, 1'b1); drain();
        issue(32'd9, 32'd5, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 4, 1'b1); drain();
        issue(32'hCAFEF00D, 32'hCAFEF00D, 3'b010, 1'b0, 1'b0, 1'b1, 1'b1, 4, 1'b1); drain();
        issue(32'hCAFEF00D, 32'hCAFEF00D, 3'b100, 1'b0, 1'b0, 1'b1, 1'b0, 4, 1'b1); drain();
        issue(32'hFFFFFFFE, 32'hFFFFFFFF, 3'b000, 1'b1, 1'b1, 1'b0, 1'b1, 4, 1'b1); drain();
        issue(32'h7FFFFFFF, 32'h80000000, 3'b001, 1'b1, 1'b0, 1'b0, 1'b1, 1, 1'b1); drain();
        issue(32'h7FFFFFFF, 32'h80000000, 3'b001, 1'b0, 1'b1, 1'b0, 1'b0, 1, 1'b1); drain();

        // Backpressure: result held while new requests are offered and ignored.
        bus.out_ready = 1'b0;
        issue(32'h12345678, 32'h12345678, 3'b110, 1'b0, 1'b0, 1'b1, 1'b1, 4, 1'b1);
        guard = 0;
        while (!bus.out_valid && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 20) chk("bp_valid_timeout", 0, 1);
        repeat (5) begin
            @(posedge clk); #1;
            bus.src_a = $urandom;
            bus.src_b = 32'h0;
            bus.in_valid = 1'b1;
            chk("bp_hold", int'({bus.out_valid, bus.in_ready, bus.less, bus.equal,
                                 bus.cmp_result, bus.slices_used}),
                int'({1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'd4}));
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_in_ready_after", int'(bus.in_ready), 1);
        @(posedge clk); #1;
        chk("bp_no_capture", int'(bus.out_valid), 0);
        chk("bp_queue_empty", q.size(), 0);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
